// File: rtl/mnist_in_pkg.sv
// Shared definitions for the MNIST LogicNet input front end.
// Contents: frame geometry localparams and the binarizer FSM state type.
package mnist_in_pkg;

    localparam int unsigned NUM_PIXELS = 784;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned CNT_W      = 10;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/mnist_input_binarizer.sv
// MNIST input binarizer: thresholds a stream of 8-bit grayscale pixels and
// packs one bit per pixel into a single held frame vector for layer 0.
// Optional build macro: MNIST_FRAME_CHECK_EN (adds s_last / frame_err).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   thresh_i       binarization threshold, sampled on pixel 0 of each frame
//   s_valid/ready  pixel handshake, s_pixel unsigned pixel value
//   s_last         (frame check only) end-of-frame marker on pixel handshake
//   m_valid/ready  frame handshake to the layer-0 neuron bank
//   m_data         packed binarized frame, bit i = pixel i
//   frame_cnt      frames delivered, wraps modulo 2^16
//   frame_err      (frame check only) sticky framing error
module mnist_input_binarizer
    import mnist_in_pkg::*;
#(
    parameter logic [PIX_W-1:0] THRESH_RST = PIX_W'(128)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIX_W-1:0]      thresh_i,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [PIX_W-1:0]      s_pixel,
`ifdef MNIST_FRAME_CHECK_EN
    input  logic                  s_last,
    output logic                  frame_err,
`endif
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [NUM_PIXELS-1:0] m_data,
    output logic [15:0]           frame_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

    state_t           state;
    logic [CNT_W-1:0] pix_cnt;
    logic [PIX_W-1:0] thr_q;

    logic             accept;
    logic             first_pix;
    logic             last_pix;
    logic [PIX_W-1:0] thr;

    // Ready is a pure decode of the registered state.
    assign s_ready   = (state == FILL);
    assign accept    = s_valid & s_ready;
    assign first_pix = (pix_cnt == '0);
    assign last_pix  = (pix_cnt == LAST_IDX);
    // Pixel 0 uses the live threshold; the rest of the frame uses the latched copy.
    assign thr       = first_pix ? thresh_i : thr_q;

    // Frame fill / hold controller with compare-and-pack datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            pix_cnt   <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            frame_cnt <= '0;
            thr_q     <= THRESH_RST;
`ifdef MNIST_FRAME_CHECK_EN
            frame_err <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (first_pix) begin
                            thr_q <= thresh_i;
                        end
                        m_data[pix_cnt] <= (s_pixel >= thr);
`ifdef MNIST_FRAME_CHECK_EN
                        if (s_last && !last_pix) begin
                            // Early end marker: drop the partial frame.
                            frame_err <= 1'b1;
                            pix_cnt   <= '0;
                        end else if (last_pix) begin
                            if (!s_last) begin
                                frame_err <= 1'b1;
                            end
                            pix_cnt <= '0;
                            state   <= HOLD;
                            m_valid <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + CNT_W'(1);
                        end
`else
                        if (last_pix) begin
                            pix_cnt <= '0;
                            state   <= HOLD;
                            m_valid <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + CNT_W'(1);
                        end
`endif
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        state     <= FILL;
                        m_valid   <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                default: begin
                    state   <= FILL;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_input_binarizer.sv
// Self-checking bench for mnist_input_binarizer: expected frames are queued as
// pixels are driven and compared when the DUT completes a frame handshake.
module tb_mnist_input_binarizer;
    import mnist_in_pkg::*;

    typedef logic [NUM_PIXELS-1:0] frame_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [PIX_W-1:0] thresh_i;
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_pixel;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    frame_t           m_data;
    logic [15:0]      frame_cnt;
`ifdef MNIST_FRAME_CHECK_EN
    logic             frame_err;
`endif

    frame_t      exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned acc_cnt  = 0;
    int unsigned last_cnt = 0;

    always #5 clk = ~clk;

    mnist_input_binarizer dut (
        .clk       (clk),
        .rst       (rst),
        .thresh_i  (thresh_i),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_pixel   (s_pixel),
`ifdef MNIST_FRAME_CHECK_EN
        .s_last    (s_last),
        .frame_err (frame_err),
`endif
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .frame_cnt (frame_cnt)
    );

    task automatic check(input string tag, input frame_t obs, input frame_t exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: counts pixel handshakes and scores every delivered frame.
    always @(negedge clk) begin
        if (!rst && s_valid && s_ready) begin
            acc_cnt++;
            if (s_last) last_cnt++;
        end
        if (!rst && m_valid && m_ready) begin
            check("frame_expected", frame_t'(exp_q.size() > 0), frame_t'(1));
            if (exp_q.size() > 0) begin
                check("frame_data", m_data, exp_q.pop_front());
            end
        end
    end

    task automatic send_pixel(input logic [PIX_W-1:0] p, input logic [PIX_W-1:0] t,
                              input logic last, input bit gaps);
        bit ok;
        if (gaps) begin
            for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid  = 1'b1;
        s_pixel  = p;
        thresh_i = t;
        s_last   = last;
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!ok) check("pixel_accept_timeout", frame_t'(0), frame_t'(1));
    endtask

    // Drives n pixels (ramp i mod 256 or constant val); thresholds t0 on pixel 0, t1 after.
    task automatic send_frame(input int n, input bit ramp, input logic [PIX_W-1:0] val,
                              input logic [PIX_W-1:0] t0, input logic [PIX_W-1:0] t1,
                              input bit gaps, input bit push, input int last_idx);
        frame_t e;
        logic [PIX_W-1:0] p;
        e = '0;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            p = ramp ? PIX_W'(i) : val;
            e[i] = (p >= t0);
        end
        if (push) exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            p = ramp ? PIX_W'(i) : val;
            send_pixel(p, (i == 0) ? t0 : t1, (i == last_idx), gaps);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        check(tag, frame_t'(exp_q.size()), frame_t'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        repeat (2) begin
            @(negedge clk);
            check("rst_m_valid", frame_t'(m_valid), frame_t'(0));
            check("rst_m_data", m_data, frame_t'(0));
            check("rst_frame_cnt", frame_t'(frame_cnt), frame_t'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t      e;
        int unsigned acc0;

        rst = 1'b1; thresh_i = '0; s_valid = 1'b0; s_pixel = '0;
        s_last = 1'b0; m_ready = 1'b0;
        do_reset();
        @(negedge clk);
        check("reset_s_ready", frame_t'(s_ready), frame_t'(1));
        @(posedge clk); #1;

        // Ramp frame, threshold 128, consumer always ready.
        m_ready = 1'b1;
        acc0 = acc_cnt;
        send_frame(NUM_PIXELS, 1'b1, '0, 8'd128, 8'd128, 1'b0, 1'b1, NUM_PIXELS - 1);
        @(negedge clk);
        check("t1_m_valid_latency", frame_t'(m_valid), frame_t'(1));
        @(posedge clk); #1;
        check("t1_frame_cnt", frame_t'(frame_cnt), frame_t'(1));
        check("t1_pixel_count", frame_t'(acc_cnt - acc0), frame_t'(NUM_PIXELS));
        @(negedge clk);
        check("t1_m_valid_drop", frame_t'(m_valid), frame_t'(0));
        @(posedge clk); #1;

        // Backpressure: frame held for 50 cycles while upstream keeps offering.
        m_ready = 1'b0;
        send_frame(NUM_PIXELS, 1'b1, '0, 8'd64, 8'd64, 1'b0, 1'b1, NUM_PIXELS - 1);
        e = exp_q[exp_q.size() - 1];
        s_valid = 1'b1; s_pixel = 8'd7;
        acc0 = acc_cnt;
        repeat (50) begin
            @(negedge clk);
            check("t2_s_ready_low", frame_t'(s_ready), frame_t'(0));
            check("t2_m_data_stable", m_data, e);
            @(posedge clk); #1;
        end
        check("t2_no_consume", frame_t'(acc_cnt - acc0), frame_t'(0));
        m_ready = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        check("t2_s_ready_in_hs", frame_t'(s_ready), frame_t'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_s_ready_after_hs", frame_t'(s_ready), frame_t'(1));
        check("t2_frame_cnt", frame_t'(frame_cnt), frame_t'(2));
        @(posedge clk); #1;

        // Threshold latched at pixel 0 (0), later changes to 255 ignored.
        send_frame(NUM_PIXELS, 1'b0, 8'd10, 8'd0, 8'd255, 1'b0, 1'b1, NUM_PIXELS - 1);
        wait_idle("t3_drain");

        // Random valid gaps: all-255 then all-0 frames.
        do_reset();
        acc0 = acc_cnt;
        send_frame(NUM_PIXELS, 1'b0, 8'd255, 8'd128, 8'd128, 1'b1, 1'b1, NUM_PIXELS - 1);
        send_frame(NUM_PIXELS, 1'b0, 8'd0, 8'd128, 8'd128, 1'b1, 1'b1, NUM_PIXELS - 1);
        wait_idle("t4_drain");
        check("t4_frame_cnt", frame_t'(frame_cnt), frame_t'(2));
        check("t4_pixel_count", frame_t'(acc_cnt - acc0), frame_t'(2 * NUM_PIXELS));

        // Reset mid-frame, then a clean all-200 frame at threshold 100.
        send_frame(400, 1'b0, 8'd0, 8'd255, 8'd255, 1'b0, 1'b0, -1);
        do_reset();
        send_frame(NUM_PIXELS, 1'b0, 8'd200, 8'd100, 8'd100, 1'b0, 1'b1, NUM_PIXELS - 1);
        wait_idle("t5_drain");
        check("t5_frame_cnt", frame_t'(frame_cnt), frame_t'(1));

`ifdef MNIST_FRAME_CHECK_EN
        // Early end marker drops the partial frame and flags a sticky error.
        do_reset();
        send_frame(500, 1'b0, 8'd255, 8'd128, 8'd128, 1'b0, 1'b0, 499);
        repeat (20) begin
            @(negedge clk);
            check("t6_no_m_valid", frame_t'(m_valid), frame_t'(0));
            check("t6_frame_err", frame_t'(frame_err), frame_t'(1));
            @(posedge clk); #1;
        end
        send_frame(NUM_PIXELS, 1'b0, 8'd255, 8'd128, 8'd128, 1'b0, 1'b1, NUM_PIXELS - 1);
        wait_idle("t6_drain");
        check("t6_frame_err_sticky", frame_t'(frame_err), frame_t'(1));
        check("t6_frame_cnt", frame_t'(frame_cnt), frame_t'(1));
`endif

        check("final_queue_empty", frame_t'(exp_q.size()), frame_t'(0));
        $display("info: %0d pixels accepted, %0d flagged last", acc_cnt, last_cnt);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
